// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and clear-sequence state encoding
package rf_pkg;
  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} clr_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits for the issue stage
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr0_en_i,
  input  logic [ADDR_W-1:0] clr0_addr_i,
  input  logic              clr1_en_i,
  input  logic [ADDR_W-1:0] clr1_addr_i,
  input  logic              wipe_en_i,
  input  logic [ADDR_W-1:0] wipe_idx_i,
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              pend_a_o,
  output logic              pend_b_o
);
  logic [NUM_REGS-1:0] pend_q, pend_d;
  // clears first so a same-cycle reservation wins
  always_comb begin
    pend_d = pend_q;
    if (wipe_en_i) pend_d[wipe_idx_i] = 1'b0;
    if (clr0_en_i) pend_d[clr0_addr_i] = 1'b0;
    if (clr1_en_i) pend_d[clr1_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end
  // pending state, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else pend_q <= pend_d;
  end
  assign pend_a_o = (!busy_i && 32'(rd_addr_a_i) < NUM_REGS) ? pend_q[rd_addr_a_i] : 1'b0;
  assign pend_b_o = (!busy_i && 32'(rd_addr_b_i) < NUM_REGS) ? pend_q[rd_addr_b_i] : 1'b0;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2R/2W register file with bypass, zero R0, scoreboard and clear engine
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter bit ZERO_R0  = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              pend_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  clr_state_e st_q, st_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic busy, we0, we1, rsv_ok;
  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rdv;

  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS && !(ZERO_R0 && a == '0);
  endfunction

  assign busy = st_q != IDLE;
  assign clr_busy = busy;
  assign we0 = wr_en0 && !busy && ok(wr_addr0);
  assign we1 = wr_en1 && !busy && ok(wr_addr1);
  assign rsv_ok = rsv_en && !busy && ok(rsv_addr);
  assign ra = {rd_addr_b, rd_addr_a};
  assign rd_data_a = rdv[0];
  assign rd_data_b = rdv[1];

  // clear engine sweeps every index once, then spends one cycle in DONE
  always_comb begin
    st_d = (st_q == IDLE && clr_req) ? CLEAR :
           (st_q == CLEAR && idx_q == LAST) ? DONE :
           (st_q == DONE) ? IDLE : st_q;
    idx_d = (st_q == CLEAR && idx_q != LAST) ? idx_q + 1'b1 : '0;
  end

  // clear-engine state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= IDLE;
      idx_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  // storage: clear wipe, then port 0, then port 1 so port 1 wins a collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      if (st_q == CLEAR) mem_q[idx_q] <= '0;
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  // read muxes: bypass from accepted writes, masked for range, R0 and clear
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdv[p] = (busy || 32'(ra[p]) >= NUM_REGS || (ZERO_R0 && ra[p] == '0)) ? '0 :
               (BYPASS && we1 && wr_addr1 == ra[p]) ? wr_data1 :
               (BYPASS && we0 && wr_addr0 == ra[p]) ? wr_data0 : mem_q[ra[p]];
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (rsv_ok),
    .set_addr_i (rsv_addr),
    .clr0_en_i  (we0),
    .clr0_addr_i(wr_addr0),
    .clr1_en_i  (we1),
    .clr1_addr_i(wr_addr1),
    .wipe_en_i  (st_q == CLEAR),
    .wipe_idx_i (idx_q),
    .busy_i     (busy),
    .rd_addr_a_i(rd_addr_a),
    .rd_addr_b_i(rd_addr_b),
    .pend_a_o   (pend_a),
    .pend_b_o   (pend_b)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks against an array-based model
module tb_reg_file_mp;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  logic clk = 1'b0, rst = 1'b0;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr0, wr_addr1, rsv_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data0, wr_data1;
  logic pend_a, pend_b, wr_en0, wr_en1, rsv_en, clr_req, clr_busy;
  int checks = 0, errors = 0;
  logic [DW-1:0] m_mem [NR];
  bit m_pend [NR];
  int m_left;
  int n_busy;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .pend_a(pend_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .pend_b(pend_b),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_left > 0 || a == 0) return '0;
    if (wr_en1 && wr_addr1 == a) return wr_data1;
    if (wr_en0 && wr_addr0 == a) return wr_data0;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    return m_left > 0 ? 1'b0 : m_pend[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
  endtask

  task automatic idle_in();
    wr_en0 = 0; wr_en1 = 0; rsv_en = 0; clr_req = 0;
  endtask

  task automatic step();
    @(negedge clk);
    chk("rd_a", 32'(rd_data_a), 32'(exp_rd(rd_addr_a)));
    chk("rd_b", 32'(rd_data_b), 32'(exp_rd(rd_addr_b)));
    chk("pend_a", 32'(pend_a), 32'(exp_pend(rd_addr_a)));
    chk("pend_b", 32'(pend_b), 32'(exp_pend(rd_addr_b)));
    chk("busy", 32'(clr_busy), 32'(m_left > 0));
    if (clr_busy) n_busy++;
    @(posedge clk);
    if (m_left > 0) m_left--;
    else begin
      if (wr_en0 && wr_addr0 != 0) begin m_mem[wr_addr0] = wr_data0; m_pend[wr_addr0] = 0; end
      if (wr_en1 && wr_addr1 != 0) begin m_mem[wr_addr1] = wr_data1; m_pend[wr_addr1] = 0; end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
      if (clr_req) begin
        model_reset();
        m_left = NR + 1;
      end
    end
    #1;
  endtask

  task automatic sweep();
    idle_in();
    for (int a = 0; a < NR; a++) begin
      rd_addr_a = AW'(a);
      rd_addr_b = AW'(NR - 1 - a);
      step();
    end
  endtask

  initial begin
    idle_in();
    rd_addr_a = 0; rd_addr_b = 0; wr_addr0 = 0; wr_addr1 = 0; rsv_addr = 0;
    wr_data0 = 0; wr_data1 = 0;
    model_reset();
    #12 rst = 1;
    @(posedge clk); #1;
    sweep();

    wr_en0 = 1; wr_addr0 = 5; wr_data0 = 16'h1111;
    wr_en1 = 1; wr_addr1 = 5; wr_data1 = 16'h2222;
    rd_addr_a = 5; #1;
    chk("collide_bypass", 32'(rd_data_a), 32'h2222);
    step();
    idle_in(); #1;
    chk("collide_stored", 32'(rd_data_a), 32'h2222);
    step();

    wr_en0 = 1; wr_addr0 = 0; wr_data0 = 16'hFFFF;
    wr_en1 = 1; wr_addr1 = 0; wr_data1 = 16'hFFFF;
    rsv_en = 1; rsv_addr = 0; rd_addr_a = 0; #1;
    chk("r0_bypass", 32'(rd_data_a), 32'h0);
    step();
    idle_in(); #1;
    chk("r0_data", 32'(rd_data_a), 32'h0);
    chk("r0_pend", 32'(pend_a), 32'h0);
    repeat (3) step();

    rsv_en = 1; rsv_addr = 3; rd_addr_a = 3; #1;
    chk("rsv3_same_cycle", 32'(pend_a), 32'h0);
    step();
    idle_in(); #1;
    chk("rsv3_set", 32'(pend_a), 32'h1);
    repeat (2) step();
    wr_en0 = 1; wr_addr0 = 3; wr_data0 = 16'h0333; #1;
    chk("wr3_pend_still", 32'(pend_a), 32'h1);
    step();
    idle_in(); #1;
    chk("wr3_pend_clr", 32'(pend_a), 32'h0);
    chk("wr3_data", 32'(rd_data_a), 32'h0333);
    rsv_en = 1; rsv_addr = 7; wr_en1 = 1; wr_addr1 = 7; wr_data1 = 16'hABCD; rd_addr_b = 7;
    step();
    idle_in(); #1;
    chk("rsv_wr7_pend", 32'(pend_b), 32'h1);
    chk("rsv_wr7_data", 32'(rd_data_b), 32'hABCD);
    step();

    for (int a = 1; a < NR; a++) begin
      wr_en0 = 1; wr_addr0 = AW'(a); wr_data0 = DW'(a * 16'h1010 + 1);
      step();
    end
    idle_in(); clr_req = 1; step();
    clr_req = 0; n_busy = 0;
    for (int k = 0; k < NR + 1; k++) begin
      wr_en0 = 1; wr_addr0 = 2; wr_data0 = 16'h5555; rd_addr_a = 2;
      step();
    end
    idle_in();
    step();
    chk("busy_cycles", 32'(n_busy), 32'(NR + 1));
    #1 chk("wr2_dropped", 32'(rd_data_a), 32'h0);
    wr_en0 = 1; wr_addr0 = 2; wr_data0 = 16'h1234; step();
    idle_in(); #1;
    chk("wr2_after_clear", 32'(rd_data_a), 32'h1234);
    sweep();

    for (int a = 1; a < NR; a++) begin
      wr_en1 = 1; wr_addr1 = AW'(a); wr_data1 = DW'($urandom);
      rsv_en = 1; rsv_addr = AW'(a);
      step();
    end
    idle_in(); clr_req = 1; step();
    clr_req = 0;
    repeat (6) step();
    #2 rst = 0;
    #1 chk("midclr_busy", 32'(clr_busy), 32'h0);
    model_reset();
    for (int a = 0; a < NR; a++) begin
      rd_addr_a = AW'(a); #1;
      chk("midclr_data", 32'(rd_data_a), 32'h0);
      chk("midclr_pend", 32'(pend_a), 32'h0);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    clr_req = 1; step();
    clr_req = 0;
    repeat (NR + 3) step();

    for (int c = 0; c < 600; c++) begin
      rd_addr_a = AW'($urandom_range(0, NR - 1));
      rd_addr_b = AW'($urandom_range(0, NR - 1));
      wr_en0 = $urandom_range(0, 1) == 1;
      wr_addr0 = AW'($urandom_range(0, NR - 1));
      wr_data0 = DW'($urandom);
      wr_en1 = $urandom_range(0, 2) == 0;
      wr_addr1 = $urandom_range(0, 3) == 0 ? wr_addr0 : AW'($urandom_range(0, NR - 1));
      wr_data1 = DW'($urandom);
      rsv_en = $urandom_range(0, 2) == 0;
      rsv_addr = $urandom_range(0, 3) == 0 ? wr_addr1 : AW'($urandom_range(0, NR - 1));
      clr_req = $urandom_range(0, 59) == 0;
      step();
    end
    idle_in();
    repeat (NR + 2) step();
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the 16x16 datapath register file: configurable width and depth, two read ports, two write ports with defined priority.
- Adds optional same-cycle write-to-read bypass, an optional hardwired-zero R0, a per-register pending scoreboard for the issue stage, and a sequential clear engine that software can trigger at run time.
- Sits between decode (read addresses, reservations) and writeback (two write ports: ALU and load).

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register address width
- NUM_REGS, 2**ADDR_W, number of registers; must be <= 2**ADDR_W
- ZERO_R0, 1, 1 = register 0 always reads 0, cannot be written and is never pending
- BYPASS, 1, 1 = a read returns a same-cycle write's data (write-first); 0 = a read returns the stored value

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  DATA_W  read port A data (combinational)
- pend_a  out  1  pending bit of rd_addr_a (combinational)
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  DATA_W  read port B data (combinational)
- pend_b  out  1  pending bit of rd_addr_b (combinational)
- wr_en0  in  1  write port 0 enable
- wr_addr0  in  ADDR_W  write port 0 address
- wr_data0  in  DATA_W  write port 0 data
- wr_en1  in  1  write port 1 enable (priority port)
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- rsv_en  in  1  reserve destination (set pending)
- rsv_addr  in  ADDR_W  register to reserve
- clr_req  in  1  start a clear sequence (pulse)
- clr_busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst=0, async): all registers = 0, all pending bits = 0, FSM = IDLE, clr_busy = 0, clear index = 0. No preload values.
- Writes take effect at posedge clk. Port 1 beats port 0 when both are enabled to the same address; only port 1's data lands.
- Addresses >= NUM_REGS: writes are ignored, reads return 0, pend returns 0.
- ZERO_R0=1: writes to address 0 are dropped; reads of address 0 return 0; a reservation of address 0 is ignored.
- Read, BYPASS=1: if wr_en1 matches rd_addr, return wr_data1; else if wr_en0 matches, return wr_data0; else return the stored value. The ZERO_R0 masking applies after the bypass.
- Read, BYPASS=0: always return the stored value.
- Scoreboard, per register:
  - rsv_en sets pend[rsv_addr] at the clock edge.
  - Any accepted write clears pend[wr_addr].
  - If a reservation and a write hit the same address in the same cycle, the set wins (pend=1, data written).
- pend_a/pend_b are combinational lookups of the current pend bits. There is no bypass on pend: a write in cycle N clears the bit from cycle N+1.
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR; index=0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle, reg[index]=0 and pend[index]=0, index++. When index = NUM_REGS-1 -> DONE.
  - DONE: one cycle, clr_busy=0 -> IDLE. A full clear takes NUM_REGS+1 cycles after clr_req.
  - While clr_busy=1: wr_en0, wr_en1 and rsv_en are ignored (dropped, not queued); reads return 0 and pend reads return 0.
  - clr_req during CLEAR or DONE is ignored.
- Reset asserted mid-clear: immediate return to the reset state; the sequence does not resume.
- No X may propagate from unwritten entries; all storage is reset.

Decomposition:
- Shared package rf_pkg: clear-FSM state enum (IDLE, CLEAR, DONE); default width and depth constants shared with the decode and writeback stages.
- One natural sub-module: rf_scoreboard. It owns the pend bit vector, the set/clear priority, the clear-index reset, and the two pend lookups.
- Storage, the bypass muxes and the FSM stay in reg_file_mp.

Test Plan:
- Reset, then read all addresses -> every rd_data = 0, every pend = 0, clr_busy = 0.
- Same-cycle write collision: wr_en0 with addr 5, data 0x1111, and wr_en1 with addr 5, data 0x2222; read addr 5 next cycle -> 0x2222. With BYPASS=1, a same-cycle read of addr 5 -> 0x2222.
- R0 protection (ZERO_R0=1): write 0xFFFF to addr 0 and rsv_en addr 0 -> rd_data = 0 and pend = 0 on all following cycles.
- Scoreboard: rsv addr 3 in cycle 1 -> pend_a(3)=1 from cycle 2. wr_en0 addr 3 in cycle 4 -> pend clears in cycle 5. rsv and write addr 7 in the same cycle -> pend=1 and data updated.
- Clear sequence: fill regs 1..15 with nonzero values, pulse clr_req -> clr_busy high for 17 cycles. A write to addr 2 during the clear is dropped. Afterwards all regs = 0, and a write accepted after clr_busy falls lands correctly.
- Reset mid-clear: assert rst at index 6 -> clr_busy = 0 immediately, all registers 0, FSM in IDLE, and a new clr_req is accepted.
